// File: rtl/cp0_ctrl.sv
// cp0_ctrl -- Coprocessor-0 exception/interrupt controller.
//
// Sits beside the M stage. It combines the hardware interrupt lines with the
// M-stage exception code, decides whether to take an exception, and holds the
// SR / Cause / EPC / PRId registers used by mfc0 / mtc0 / eret.
//
// Ports:
//   clk        in   clock; all state updates on its rising edge
//   reset      in   asynchronous, active-low clear
//   A1         in   [4:0]  CP0 register number for the read (DOut)
//   A2         in   [4:0]  CP0 register number for the mtc0 write
//   DIn        in   [31:0] mtc0 write data
//   WE         in   mtc0 write enable
//   VPC        in   [31:0] PC of the instruction in M
//   BDIn       in   M instruction sits in a branch delay slot
//   ExcCodeIn  in   [4:0]  M-stage exception code, 0 = none
//   HWInt      in   [5:0]  level-sensitive hardware interrupt lines
//   EXLClr     in   eret in M
//   IntReq     out  take an exception this cycle
//   EPC_out    out  [31:0] current EPC value
//   DOut       out  [31:0] read data for A1
module cp0_ctrl #(
  parameter logic [31:0] PRID = 32'h2021_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC_out,
  output logic [31:0] DOut
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // Only the implemented fields are stored; EPC keeps just the word address.
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [29:0] epc_q, epc_d;

  logic irq;
  logic exc;

  assign irq = (|(HWInt & im_q)) & ie_q & ~exl_q;
  assign exc = (ExcCodeIn != 5'd0) & ~exl_q;
  // The exception-code input is live even while reset is low, so gate it.
  assign IntReq = (irq | exc) & reset;

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (IntReq) begin
      exl_d      = 1'b1;
      exc_code_d = irq ? 5'd0 : ExcCodeIn;
      bd_d       = BDIn;
      // Word-address subtract of 1 == byte-address subtract of 4; wraps mod 2^32.
      epc_d      = BDIn ? (VPC[31:2] - 30'd1) : VPC[31:2];
    end else begin
      if (WE && (A2 == REG_SR)) begin
        im_d  = DIn[15:10];
        exl_d = DIn[1];
        ie_d  = DIn[0];
      end
      if (WE && (A2 == REG_EPC)) begin
        epc_d = DIn[31:2];
      end
      // Placed after the SR write so eret wins on EXL when both coincide.
      if (EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 30'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= HWInt;   // IP tracks the lines every cycle, even with EXL set
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  assign EPC_out = {epc_q, 2'b00};

  always_comb begin
    DOut = 32'd0;
    case (A1)
      REG_SR:    DOut = {16'd0, im_q, 8'd0, exl_q, ie_q};
      REG_CAUSE: DOut = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'b00};
      REG_EPC:   DOut = {epc_q, 2'b00};
      REG_PRID:  DOut = PRID;
      default:   DOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
module tb_cp0_ctrl;

  localparam logic [31:0] PRID = 32'h2021_0007;

  logic        clk;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC_out;
  logic [31:0] DOut;

  cp0_ctrl #(.PRID(PRID)) dut (
    .clk       (clk),
    .reset     (reset),
    .A1        (A1),
    .A2        (A2),
    .DIn       (DIn),
    .WE        (WE),
    .VPC       (VPC),
    .BDIn      (BDIn),
    .ExcCodeIn (ExcCodeIn),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .IntReq    (IntReq),
    .EPC_out   (EPC_out),
    .DOut      (DOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Push the expected value for the next comparison.
  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the observed value.
  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_total = n_total + 1;
    if (sb_q.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) n_pass = n_pass + 1;
      else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      $display("check %-16s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic rd(input logic [4:0] addr);
    A1 = addr;
    #1;
    check(DOut);
  endtask

  task automatic chk_irq();
    #1;
    check({31'd0, IntReq});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; WE = 1'b0;
    VPC = 32'd0; BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;

    // Reset: exception code present but IntReq forced low.
    tick();
    ExcCodeIn = 5'd5;
    expect_val("irq_in_reset", 32'd0); chk_irq();
    ExcCodeIn = 5'd0;
    tick(); tick();
    reset = 1'b1;
    tick();
    expect_val("rst_sr", 32'd0);      rd(5'd12);
    expect_val("rst_cause", 32'd0);   rd(5'd13);
    expect_val("rst_epc", 32'd0);     rd(5'd14);
    expect_val("rst_prid", PRID);     rd(5'd15);
    expect_val("rst_unimpl", 32'd0);  rd(5'd3);
    expect_val("rst_intreq", 32'd0);  chk_irq();
    expect_val("rst_epc_out", 32'd0); check(EPC_out);

    // Interrupt entry.
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
    tick();
    WE = 1'b0;
    expect_val("sr_written", 32'h0000_0401); rd(5'd12);
    HWInt = 6'b000001; VPC = 32'h3010; BDIn = 1'b0;
    expect_val("irq_same_cycle", 32'd1); chk_irq();
    tick();
    expect_val("irq_drop", 32'd0);          chk_irq();
    expect_val("int_epc", 32'h3010);        rd(5'd14);
    expect_val("int_sr_exl", 32'h0000_0403); rd(5'd12);
    expect_val("int_cause", 32'h0000_0400); rd(5'd13);
    expect_val("int_epc_out", 32'h3010);    check(EPC_out);
    // Masked while EXL=1.
    ExcCodeIn = 5'd12;
    expect_val("nested_masked", 32'd0); chk_irq();
    ExcCodeIn = 5'd0;

    // eret with the interrupt still pending.
    EXLClr = 1'b1; VPC = 32'h3040;
    expect_val("eret_cyc_irq", 32'd0);     chk_irq();
    expect_val("eret_epc_out", 32'h3010); check(EPC_out);
    tick();
    EXLClr = 1'b0;
    expect_val("post_eret_sr", 32'h0000_0401); rd(5'd12);
    expect_val("reassert_irq", 32'd1);         chk_irq();
    tick();
    expect_val("reentry_epc", 32'h3040);       rd(5'd14);
    expect_val("reentry_sr", 32'h0000_0403);   rd(5'd12);

    // Simultaneous interrupt and exception.
    HWInt = 6'd0; EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    HWInt = 6'b000001; ExcCodeIn = 5'd4; VPC = 32'h3050;
    expect_val("both_irq", 32'd1); chk_irq();
    tick();
    expect_val("both_cause", 32'h0000_0400); rd(5'd13);
    expect_val("both_epc", 32'h3050);        rd(5'd14);
    expect_val("both_single", 32'd0);        chk_irq();

    // eret coinciding with mtc0 SR: EXL ends 0, IM/IE written.
    HWInt = 6'd0; ExcCodeIn = 5'd0;
    EXLClr = 1'b1; WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_8403;
    tick();
    EXLClr = 1'b0;
    expect_val("eret_mtc0_sr", 32'h0000_8401); rd(5'd12);
    DIn = 32'd0;
    tick();
    WE = 1'b0;
    expect_val("sr_cleared", 32'd0); rd(5'd12);

    // Delay-slot exception with IE=0; coincident mtc0 EPC is dropped.
    ExcCodeIn = 5'd12; VPC = 32'h3024; BDIn = 1'b1;
    WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_DEAD;
    expect_val("ds_irq", 32'd1); chk_irq();
    tick();
    WE = 1'b0; ExcCodeIn = 5'd0; BDIn = 1'b0;
    expect_val("ds_epc", 32'h3020);         rd(5'd14);
    expect_val("ds_cause", 32'h8000_0030);  rd(5'd13);
    expect_val("ds_sr", 32'h0000_0002);     rd(5'd12);

    // EPC wrap at VPC=0 in a delay slot.
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    ExcCodeIn = 5'd4; VPC = 32'd0; BDIn = 1'b1;
    tick();
    ExcCodeIn = 5'd0; BDIn = 1'b0;
    expect_val("wrap_epc", 32'hFFFF_FFFC);   rd(5'd14);
    expect_val("wrap_cause", 32'h8000_0010); rd(5'd13);

    // mtc0 EPC: no bypass, visible next cycle, low bits dropped.
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    WE = 1'b1; A2 = 5'd14; DIn = 32'h1234_5677;
    expect_val("epc_no_bypass", 32'hFFFF_FFFC); rd(5'd14);
    tick();
    expect_val("epc_written", 32'h1234_5674);     rd(5'd14);
    expect_val("epc_out_written", 32'h1234_5674); check(EPC_out);
    A2 = 5'd13; DIn = 32'hFFFF_FFFF;
    tick();
    A2 = 5'd15;
    tick();
    WE = 1'b0;
    expect_val("cause_ro", 32'h8000_0010); rd(5'd13);
    expect_val("prid_ro", PRID);           rd(5'd15);

    // Asynchronous reset mid-operation clears a pending EXL at once.
    ExcCodeIn = 5'd8; VPC = 32'h4000;
    tick();
    ExcCodeIn = 5'd0;
    expect_val("pre_rst_sr", 32'h0000_0002); rd(5'd12);
    reset = 1'b0;
    expect_val("async_sr", 32'd0);  rd(5'd12);
    expect_val("async_epc", 32'd0); rd(5'd14);
    tick();
    reset = 1'b1;
    tick();
    expect_val("post_rst_cause", 32'd0); rd(5'd13);

    if (sb_q.size() != 0) begin
      n_total = n_total + 1;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cp0_ctrl.md
# cp0_ctrl

Coprocessor-0 exception/interrupt controller for the P7 pipelined MIPS CPU. Sits beside the M stage: it collects hardware interrupt lines and pipeline exception codes, and decides whether to take an exception. It drives `IntReq` and `EPC_out` into the fetch stage's next-PC selection, so the fetch stage redirects to the handler or returns on `eret`. It also holds the SR/Cause/EPC/PRId registers read by `mfc0` and written by `mtc0`.

## Interface
- `PRID`, default 32'h2021_0007: constant value returned for PRId (reg 15).
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low. Low clears all state immediately.
- `A1` input 5: CP0 register number for the read.
- `A2` input 5: CP0 register number for the write.
- `DIn` input 32: `mtc0` write data.
- `WE` input 1: `mtc0` write enable.
- `VPC` input 32: PC of the instruction currently in M.
- `BDIn` input 1: the M instruction is in a branch delay slot.
- `ExcCodeIn` input 5: M-stage exception code; 0 means none.
- `HWInt` input 6: hardware interrupt lines, level-sensitive.
- `EXLClr` input 1: `eret` in M.
- `IntReq` output 1: take exception this cycle.
- `EPC_out` output 32: current EPC register value.
- `DOut` output 32: read data for `A1`.

## Operation
- **SR (12):**
  - `IM`=SR[15:10], `EXL`=SR[1], `IE`=SR[0].
  - All other bits are held 0 and read as 0.
- **Cause (13):**
  - `BD`=[31], `IP`=[15:10], `ExcCode`=[6:2]; other bits read 0.
  - `IP` <= `HWInt` every cycle, including while `EXL`=1.
- **EPC (14):** 32-bit register; bits [1:0] are always 0.
- **PRId (15):** reads `PRID`.
- **Unimplemented registers:** any other `A1` reads 0.
- **Interrupt and exception decode (combinational):**
  - `irq` = |(`HWInt` & `IM`) & `IE` & !`EXL`.
  - `exc` = (`ExcCodeIn` != 0) & !`EXL`.
  - `IntReq` = `irq` | `exc`, forced 0 while `reset` is low.
- **Exception entry (rising edge with `IntReq`=1):**
  - `EXL` <= 1.
  - `ExcCode` <= `irq` ? 0 : `ExcCodeIn`. Interrupts have priority over exceptions.
  - `BD` <= `BDIn`.
  - `EPC` <= `BDIn` ? {`VPC`[31:2],2'b00} - 4 : {`VPC`[31:2],2'b00}.
  - Subtraction wraps modulo 2^32: `VPC`=0 with `BDIn`=1 gives 32'hFFFF_FFFC.
- **`mtc0` (rising edge with `WE`=1 and `IntReq`=0):**
  - `A2`=12: writes `IM`, `EXL`, `IE` from the matching `DIn` bits.
  - `A2`=14: writes `EPC` <= {`DIn`[31:2],2'b00}.
  - Writes to 13, 15 or other registers are ignored.
- **`eret` (rising edge with `EXLClr`=1 and `IntReq`=0):** `EXL` <= 0.
- **Priority on one edge:** exception entry > `eret` > `mtc0`.
  - When `IntReq`=1, `WE` and `EXLClr` are discarded.
  - When `eret` and an `mtc0` to SR coincide, `EXL` ends 0; the `IM`/`IE` fields are still written.
- **Read path:** `DOut` is combinational from the current register state. There is no write-to-read bypass, so an `mtc0` is visible on the cycle after its edge.

## Timing
- **Reset values:** SR=0, Cause=0, EPC=0, `IntReq`=0, `EPC_out`=0. `DOut`=0 except when `A1`=15, which returns `PRID`.
- **Reset mid-operation:** asserting `reset` low clears all state within the same cycle, including a pending `EXL`. Release is synchronous to the next `clk` edge.
- **`IntReq` timing:** zero latency from `HWInt`, `ExcCodeIn`, `IM`, `IE` and `EXL`. It drops on the cycle after entry, because `EXL` is then 1.
- **`EPC_out` timing:** updates one edge after entry or after an `mtc0` to EPC. The fetch stage samples it during the `eret` cycle.
- **Nested events:** while `EXL`=1, all interrupts and exceptions are masked. `HWInt` changes only update `IP`.
- **After `eret`:** a still-pending enabled interrupt re-asserts `IntReq` on the cycle after the `eret` edge.

## Test plan
- **Reset:** hold `reset`=0, then release -> SR=Cause=EPC=0, `IntReq`=0, `DOut`(`A1`=15)=`PRID`.
- **Interrupt entry:**
  - Stimulus: `mtc0` SR=32'h0000_0401, then `HWInt`=6'b000001, `VPC`=32'h3010, `BDIn`=0.
  - Response: `IntReq`=1 in the same cycle. Next cycle: EPC=32'h3010, `EXL`=1, `ExcCode`=0, `IntReq`=0, `IP`=1.
- **Delay-slot exception:**
  - Stimulus: `ExcCodeIn`=5'd12, `VPC`=32'h3024, `BDIn`=1, SR=0.
  - Response: EPC=32'h3020, `BD`=1, `ExcCode`=12. This holds even with `IE`=0.
- **Simultaneous interrupt and exception:** `HWInt` enabled with `ExcCodeIn`=4 -> `ExcCode`=0, a single entry.
- **`mtc0` during entry:** `WE`=1, `A2`=14, `DIn`=32'hDEAD in the same cycle as `IntReq`=1 -> EPC holds `VPC`, not 32'hDEAD.
- **`eret` with pending interrupt:** assert `EXLClr` while `EXL`=1 and the interrupt is still asserted -> `EXL`=0 next cycle and `IntReq` re-asserts, giving a new entry with an updated EPC.
